// File: rtl/uart_program_loader.sv
// -----------------------------------------------------------------------------
// uart_program_loader
//
// Parses a framed byte stream from the UART RX FIFO:
//   A5, N, 2*N data bytes (little-endian 16-bit words), CSUM
// N = 0 means 256 words. Each word is written to consecutive instruction-memory
// addresses. The frame is closed by an 8-bit modulo-256 checksum over the data
// bytes, and the loader answers with ACK_BYTE or NAK_BYTE on the TX FIFO. The
// processor is held in reset (cpu_run = 0) until a frame loads successfully.
//
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   r_data, rx_empty      head of RX FIFO and its empty flag
//   rd_uart               one-cycle RX FIFO pop
//   w_data, wr_uart       byte and one-cycle push to TX FIFO
//   tx_full               TX FIFO full flag
//   mem_we, mem_addr,
//   mem_wdata             one-cycle instruction-memory write
//   cpu_run               processor released from reset
//   busy                  frame in progress or response pending
//   load_ok               last completed frame was accepted (sticky)
// -----------------------------------------------------------------------------
module uart_program_loader #(
    parameter int         ADDR_W         = 8,
    parameter int         TIMEOUT_CYCLES = 50_000_000,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        r_data,
    input  logic              rx_empty,
    output logic              rd_uart,
    output logic [7:0]        w_data,
    output logic              wr_uart,
    input  logic              tx_full,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              load_ok
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CNT  = 3'd1,
        S_LO   = 3'd2,
        S_HI   = 3'd3,
        S_WR   = 3'd4,
        S_CSUM = 3'd5,
        S_RESP = 3'd6,
        S_RUN  = 3'd7
    } state_t;

    localparam logic [7:0]  HDR_BYTE = 8'hA5;
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_r;
    logic [7:0]  n_r;
    logic [7:0]  lo_r;
    logic [7:0]  hi_r;
    logic [7:0]  csum_r;
    logic [8:0]  idx_r;
    logic [31:0] tmo_r;

    logic        accept_s;
    logic        tmo_hit_s;
    logic [8:0]  word_total_s;
    logic        last_word_s;

    // Modulo-256 running checksum step.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

    // The FIFO head only advances after the pop cycle, so a byte is taken only
    // while no pop is in flight; this gives the two-cycle minimum per byte.
    assign accept_s     = !rx_empty && !rd_uart;
    assign tmo_hit_s    = (tmo_r >= TMO_LAST);
    assign word_total_s = (n_r == 8'd0) ? 9'd256 : {1'b0, n_r};
    assign last_word_s  = ((idx_r + 9'd1) == word_total_s);

    // Frame-parsing state machine; every output is a register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= S_IDLE;
            n_r       <= 8'd0;
            lo_r      <= 8'd0;
            hi_r      <= 8'd0;
            csum_r    <= 8'd0;
            idx_r     <= 9'd0;
            tmo_r     <= 32'd0;
            rd_uart   <= 1'b0;
            wr_uart   <= 1'b0;
            w_data    <= 8'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 16'd0;
            cpu_run   <= 1'b0;
            busy      <= 1'b0;
            load_ok   <= 1'b0;
        end else begin
            rd_uart <= 1'b0;
            wr_uart <= 1'b0;
            mem_we  <= 1'b0;
            case (state_r)
                S_IDLE, S_RUN: begin
                    tmo_r   <= 32'd0;
                    cpu_run <= (state_r == S_RUN);
                    if (accept_s) begin
                        rd_uart <= 1'b1;
                        // A header starts a new frame; anything else is dropped.
                        if (r_data == HDR_BYTE) begin
                            load_ok <= 1'b0;
                            idx_r   <= 9'd0;
                            csum_r  <= 8'd0;
                            cpu_run <= 1'b0;
                            busy    <= 1'b1;
                            state_r <= S_CNT;
                        end
                    end
                end
                S_CNT: begin
                    if (accept_s) begin
                        rd_uart <= 1'b1;
                        n_r     <= r_data;
                        tmo_r   <= 32'd0;
                        state_r <= S_LO;
                    end else if (tmo_hit_s) begin
                        w_data  <= NAK_BYTE;
                        tmo_r   <= 32'd0;
                        state_r <= S_RESP;
                    end else begin
                        tmo_r <= tmo_r + 32'd1;
                    end
                end
                S_LO: begin
                    if (accept_s) begin
                        rd_uart <= 1'b1;
                        lo_r    <= r_data;
                        csum_r  <= csum_add(csum_r, r_data);
                        tmo_r   <= 32'd0;
                        state_r <= S_HI;
                    end else if (tmo_hit_s) begin
                        w_data  <= NAK_BYTE;
                        tmo_r   <= 32'd0;
                        state_r <= S_RESP;
                    end else begin
                        tmo_r <= tmo_r + 32'd1;
                    end
                end
                S_HI: begin
                    if (accept_s) begin
                        rd_uart <= 1'b1;
                        hi_r    <= r_data;
                        csum_r  <= csum_add(csum_r, r_data);
                        tmo_r   <= 32'd0;
                        state_r <= S_WR;
                    end else if (tmo_hit_s) begin
                        w_data  <= NAK_BYTE;
                        tmo_r   <= 32'd0;
                        state_r <= S_RESP;
                    end else begin
                        tmo_r <= tmo_r + 32'd1;
                    end
                end
                S_WR: begin
                    // Memory is written before the checksum is known.
                    mem_we    <= 1'b1;
                    mem_addr  <= ADDR_W'(idx_r);
                    mem_wdata <= {hi_r, lo_r};
                    idx_r     <= idx_r + 9'd1;
                    tmo_r     <= 32'd0;
                    state_r   <= last_word_s ? S_CSUM : S_LO;
                end
                S_CSUM: begin
                    if (accept_s) begin
                        rd_uart <= 1'b1;
                        tmo_r   <= 32'd0;
                        if (r_data == csum_r) begin
                            load_ok <= 1'b1;
                            w_data  <= ACK_BYTE;
                        end else begin
                            w_data  <= NAK_BYTE;
                        end
                        state_r <= S_RESP;
                    end else if (tmo_hit_s) begin
                        w_data  <= NAK_BYTE;
                        tmo_r   <= 32'd0;
                        state_r <= S_RESP;
                    end else begin
                        tmo_r <= tmo_r + 32'd1;
                    end
                end
                S_RESP: begin
                    tmo_r <= 32'd0;
                    // w_data was loaded on entry and is left untouched here.
                    if (!tx_full) begin
                        wr_uart <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= load_ok ? S_RUN : S_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    cpu_run <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_program_loader
//
// Self-checking bench for uart_program_loader: a table of directed frames,
// hand-written sequences for reload, back-pressure, timeout and reset, then
// randomized frame streams checked against a frame-level reference parser.
// -----------------------------------------------------------------------------
module tb_uart_program_loader;

    localparam int ADDR_W = 8;
    localparam int TMO    = 100;

    logic              clk;
    logic              reset_n;
    logic [7:0]        r_data;
    logic              rx_empty;
    logic              rd_uart;
    logic [7:0]        w_data;
    logic              wr_uart;
    logic              tx_full;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_run;
    logic              busy;
    logic              load_ok;

    uart_program_loader #(
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYCLES(TMO),
        .ACK_BYTE(8'h06),
        .NAK_BYTE(8'h15)
    ) dut (
        .clk(clk), .reset_n(reset_n), .r_data(r_data), .rx_empty(rx_empty),
        .rd_uart(rd_uart), .w_data(w_data), .wr_uart(wr_uart), .tx_full(tx_full),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .busy(busy), .load_ok(load_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]  rx_q[$];
    logic        stall_en = 1'b0;
    logic [23:0] got_w[$];
    logic [7:0]  got_tx[$];
    logic [7:0]  stim[$];
    logic [23:0] exp_w[$];
    logic [7:0]  exp_tx[$];
    logic        exp_ok;

    typedef struct {
        int          len;
        logic [7:0]  b[12];
        logic [7:0]  tx;
        logic        ok;
        int          nw;
        logic [15:0] w0;
        logic [15:0] w1;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(rx_q.size() == 0 && busy == 1'b0 && rd_uart == 1'b0) && n < 20000) begin
            tick();
            n++;
        end
        if (n >= 20000) begin
            tests++;
            fails++;
            $display("FAIL %s: no completion, got busy=%0b expected 0", name, busy);
        end
        repeat (3) tick();
    endtask

    task automatic wait_rx_drained(input string name);
        int n;
        n = 0;
        while (rx_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            tests++;
            fails++;
            $display("FAIL %s: rx not drained, got %0d bytes left expected 0", name, rx_q.size());
        end
    endtask

    task automatic clear_obs();
        got_w.delete();
        got_tx.delete();
    endtask

    // Frame-level reference: scan for headers and evaluate whole frames.
    task automatic run_model();
        int i;
        int words;
        logic [7:0] sum;
        logic [7:0] lo;
        logic [7:0] hi;
        exp_w.delete();
        exp_tx.delete();
        exp_ok = 1'b0;
        i = 0;
        while (i < stim.size()) begin
            if (stim[i] != 8'hA5) begin
                i++;
                continue;
            end
            words = (stim[i+1] == 8'h00) ? 256 : int'(stim[i+1]);
            sum = 8'h00;
            for (int w = 0; w < words; w++) begin
                lo = stim[i+2+2*w];
                hi = stim[i+3+2*w];
                sum = sum + lo + hi;
                exp_w.push_back({8'(w), hi, lo});
            end
            exp_ok = (stim[i+2+2*words] == sum);
            exp_tx.push_back(exp_ok ? 8'h06 : 8'h15);
            i = i + 3 + 2 * words;
        end
    endtask

    // RX FIFO model: pops on rd_uart, presents the head otherwise.
    initial begin
        r_data   = 8'h00;
        rx_empty = 1'b1;
        forever begin
            @(negedge clk);
            if (rd_uart && rx_q.size() > 0) void'(rx_q.pop_front());
            rx_empty = (rx_q.size() == 0) || (stall_en && ($urandom_range(0, 3) == 0));
            r_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        end
    end

    // Output monitor: records writes and TX bytes, checks strobe exclusivity/width.
    initial begin
        logic prev_rd;
        logic prev_wr;
        logic prev_we;
        prev_rd = 1'b0;
        prev_wr = 1'b0;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (mem_we) got_w.push_back({mem_addr, mem_wdata});
                if (wr_uart) got_tx.push_back(w_data);
                if (rd_uart || wr_uart || mem_we) begin
                    chk("strobe_excl", 32'(rd_uart) + 32'(wr_uart) + 32'(mem_we), 32'd1);
                    chk("strobe_width", {29'd0, prev_rd & rd_uart, prev_wr & wr_uart, prev_we & mem_we}, 32'd0);
                end
                prev_rd = rd_uart;
                prev_wr = wr_uart;
                prev_we = mem_we;
            end else begin
                prev_rd = 1'b0;
                prev_wr = 1'b0;
                prev_we = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int nwords;
        logic [7:0] b;
        logic [7:0] sum;

        tbl[0].len = 7;
        tbl[0].b = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[0].tx = 8'h06; tbl[0].ok = 1'b1; tbl[0].nw = 2; tbl[0].w0 = 16'h1234; tbl[0].w1 = 16'h5678;
        tbl[1].len = 5;
        tbl[1].b = '{8'hA5, 8'h01, 8'hCD, 8'hAB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[1].tx = 8'h15; tbl[1].ok = 1'b0; tbl[1].nw = 1; tbl[1].w0 = 16'hABCD; tbl[1].w1 = 16'h0000;
        tbl[2].len = 10;
        tbl[2].b = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14, 8'h00, 8'h00};
        tbl[2].tx = 8'h06; tbl[2].ok = 1'b1; tbl[2].nw = 2; tbl[2].w0 = 16'h1234; tbl[2].w1 = 16'h5678;
        tbl[3].len = 5;
        tbl[3].b = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[3].tx = 8'h06; tbl[3].ok = 1'b1; tbl[3].nw = 1; tbl[3].w0 = 16'h0000; tbl[3].w1 = 16'h0000;
        tbl[4].len = 5;
        tbl[4].b = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[4].tx = 8'h06; tbl[4].ok = 1'b1; tbl[4].nw = 1; tbl[4].w0 = 16'hFFFF; tbl[4].w1 = 16'h0000;

        reset_n = 1'b0;
        tx_full = 1'b0;
        repeat (3) tick();
        chk("reset_ctl", {26'd0, rd_uart, wr_uart, mem_we, cpu_run, busy, load_ok}, 32'd0);
        chk("reset_data", {w_data, mem_addr, mem_wdata}, 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Directed frame table.
        for (int r = 0; r < 5; r++) begin
            clear_obs();
            for (int k = 0; k < tbl[r].len; k++) rx_q.push_back(tbl[r].b[k]);
            wait_done($sformatf("row%0d", r));
            chk($sformatf("row%0d_ntx", r), got_tx.size(), 32'd1);
            if (got_tx.size() > 0) chk($sformatf("row%0d_tx", r), {24'd0, got_tx[0]}, {24'd0, tbl[r].tx});
            chk($sformatf("row%0d_nw", r), got_w.size(), tbl[r].nw);
            if (got_w.size() > 0) chk($sformatf("row%0d_w0", r), {8'd0, got_w[0]}, {16'd0, tbl[r].w0});
            if (got_w.size() > 1 && tbl[r].nw > 1)
                chk($sformatf("row%0d_w1", r), {8'd0, got_w[1]}, {16'd1, tbl[r].w1});
            chk($sformatf("row%0d_run", r), {31'd0, cpu_run}, {31'd0, tbl[r].ok});
            chk($sformatf("row%0d_ok", r), {31'd0, load_ok}, {31'd0, tbl[r].ok});
            chk($sformatf("row%0d_busy", r), {31'd0, busy}, 32'd0);
        end

        // Reload while running: cpu_run drops with the header capture.
        clear_obs();
        rx_q.push_back(8'hA5);
        n = 0;
        while (rd_uart == 1'b0 && n < 100) begin tick(); n++; end
        chk("reload_hdr_seen", {31'd0, rd_uart}, 32'd1);
        chk("reload_run_fall", {31'd0, cpu_run}, 32'd0);
        chk("reload_busy", {31'd0, busy}, 32'd1);
        chk("reload_ok_clr", {31'd0, load_ok}, 32'd0);
        rx_q.push_back(8'h01); rx_q.push_back(8'hEF); rx_q.push_back(8'hBE); rx_q.push_back(8'hAD);
        wait_done("reload");
        chk("reload_nw", got_w.size(), 32'd1);
        if (got_w.size() > 0) chk("reload_w0", {8'd0, got_w[0]}, {8'd0, 8'd0, 16'hBEEF});
        chk("reload_ntx", got_tx.size(), 32'd1);
        if (got_tx.size() > 0) chk("reload_tx", {24'd0, got_tx[0]}, 32'h06);
        chk("reload_run", {31'd0, cpu_run}, 32'd1);

        // Back-pressure at RESP: no push while tx_full, w_data held.
        clear_obs();
        tx_full = 1'b1;
        rx_q.push_back(8'hA5); rx_q.push_back(8'h01); rx_q.push_back(8'h34);
        rx_q.push_back(8'h12); rx_q.push_back(8'h46);
        wait_rx_drained("bp_drain");
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("bp_no_wr", {31'd0, wr_uart}, 32'd0);
            chk("bp_wdata", {24'd0, w_data}, 32'h06);
        end
        tx_full = 1'b0;
        n = 0;
        while (wr_uart == 1'b0 && n < 50) begin tick(); n++; end
        chk("bp_wr_seen", {31'd0, wr_uart}, 32'd1);
        chk("bp_wdata_push", {24'd0, w_data}, 32'h06);
        wait_done("bp");
        chk("bp_ntx", got_tx.size(), 32'd1);
        chk("bp_run", {31'd0, cpu_run}, 32'd1);

        // Inter-byte timeout mid-frame.
        clear_obs();
        rx_q.push_back(8'hA5); rx_q.push_back(8'h01); rx_q.push_back(8'h34);
        wait_rx_drained("tmo_drain");
        n = 0;
        while (wr_uart == 1'b0 && n < 400) begin tick(); n++; end
        chk("tmo_wr_seen", {31'd0, wr_uart}, 32'd1);
        chk("tmo_lat_ok", {31'd0, (n >= 98 && n <= 104)}, 32'd1);
        chk("tmo_tx", {24'd0, w_data}, 32'h15);
        tick();
        chk("tmo_busy", {31'd0, busy}, 32'd0);
        chk("tmo_nw", got_w.size(), 32'd0);
        chk("tmo_ok", {31'd0, load_ok}, 32'd0);
        chk("tmo_run", {31'd0, cpu_run}, 32'd0);

        // Asynchronous reset mid-frame, then a fresh frame.
        clear_obs();
        rx_q.push_back(8'hA5); rx_q.push_back(8'h03); rx_q.push_back(8'h11);
        rx_q.push_back(8'h22); rx_q.push_back(8'h33); rx_q.push_back(8'h44);
        wait_rx_drained("rst_drain");
        repeat (3) tick();
        chk("rst_pre_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        rx_q.delete();
        #1;
        chk("rst_mid_ctl", {26'd0, rd_uart, wr_uart, mem_we, cpu_run, busy, load_ok}, 32'd0);
        chk("rst_mid_data", {w_data, mem_addr, mem_wdata}, 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        clear_obs();
        rx_q.push_back(8'hA5); rx_q.push_back(8'h01); rx_q.push_back(8'h34);
        rx_q.push_back(8'h12); rx_q.push_back(8'h46);
        wait_done("rst_fresh");
        chk("rst_fresh_nw", got_w.size(), 32'd1);
        if (got_w.size() > 0) chk("rst_fresh_w0", {8'd0, got_w[0]}, {16'd0, 16'h1234});
        chk("rst_fresh_ntx", got_tx.size(), 32'd1);
        if (got_tx.size() > 0) chk("rst_fresh_tx", {24'd0, got_tx[0]}, 32'h06);
        chk("rst_fresh_run", {31'd0, cpu_run}, 32'd1);

        // Randomized streams against the frame-level reference.
        stall_en = 1'b1;
        for (int it = 0; it < 30; it++) begin
            clear_obs();
            stim.delete();
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h00;
                stim.push_back(b);
            end
            nwords = (it == 5) ? 256 : int'($urandom_range(1, 6));
            stim.push_back(8'hA5);
            stim.push_back(8'(nwords));
            sum = 8'h00;
            for (int j = 0; j < 2 * nwords; j++) begin
                b = 8'($urandom_range(0, 255));
                sum = sum + b;
                stim.push_back(b);
            end
            if ($urandom_range(0, 2) == 0) sum = sum ^ 8'(1 << $urandom_range(0, 7));
            stim.push_back(sum);
            run_model();
            for (int j = 0; j < stim.size(); j++) rx_q.push_back(stim[j]);
            wait_done($sformatf("rnd%0d", it));
            chk($sformatf("rnd%0d_nw", it), got_w.size(), exp_w.size());
            for (int j = 0; j < got_w.size() && j < exp_w.size(); j++)
                chk($sformatf("rnd%0d_w%0d", it, j), {8'd0, got_w[j]}, {8'd0, exp_w[j]});
            chk($sformatf("rnd%0d_ntx", it), got_tx.size(), exp_tx.size());
            for (int j = 0; j < got_tx.size() && j < exp_tx.size(); j++)
                chk($sformatf("rnd%0d_tx", it), {24'd0, got_tx[j]}, {24'd0, exp_tx[j]});
            chk($sformatf("rnd%0d_run", it), {31'd0, cpu_run}, {31'd0, exp_ok});
            chk($sformatf("rnd%0d_ok", it), {31'd0, load_ok}, {31'd0, exp_ok});
        end
        stall_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
